lcd_hd44780_responder: RTL and testbench
========================================

# lcd_hd44780_responder

Synthesizable responder model of the HD44780-style character LCD, the device end of the 4-bit parallel write interface driven by the team's LCD initializer/writer. It samples `lcd_en`/`lcd_rs`/`lcd_rw`/`lcd_data` in the `clk` domain and tracks the 8-bit to 4-bit interface switch and nibble pairing. It decodes commands, maintains a 32-character DDRAM (2 lines × 16), cursor and display flags, and exposes them for on-chip checking or a shadow display.

## Interface
- `CLEAR_CYCLES`, default 152000: busy duration after Clear Display (1.52 ms at 100 MHz).
- `CMD_CYCLES`, default 3700: busy duration after any other command or data write (37 µs).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; one clock domain, reset synchronous and active-high.
- `lcd_data`  in  4  LCD data nibble (DB7..DB4).
- `lcd_rs`  in  1  register select: 0 = command, 1 = data.
- `lcd_rw`  in  1  1 = read, not supported.
- `lcd_en`  in  1  enable strobe; data latched on falling edge.
- `rd_addr`  in  5  DDRAM read index (0–15 line 0, 16–31 line 1).
- `rd_char`  out  8  DDRAM contents at `rd_addr`, registered.
- `cmd_valid`  out  1  one-cycle pulse: command byte decoded.
- `data_valid`  out  1  one-cycle pulse: data byte written.
- `byte_out`  out  8  byte accompanying either pulse.
- `cursor`  out  5  current DDRAM index.
- `four_bit`, `two_line`, `disp_on`, `cursor_on`, `blink_on`  out  1 each  mode flags.
- `busy`  out  1  modeled busy flag.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
- Reset values:
  - All outputs 0, except `rd_char` = 0x20.
  - Interface in 8-bit mode, nibble phase 0, cursor 0, increment mode.
  - DDRAM contents unchanged.
- Input capture:
  - `lcd_en`, `lcd_rs`, `lcd_rw`, `lcd_data` pass through a common 2-flop synchronizer.
  - A falling edge on the synchronized `lcd_en` captures the synchronized `lcd_rs`/`lcd_rw`/`lcd_data`.
  - A falling edge with `lcd_rw`=1 is ignored, pulses `err`, and leaves phase unchanged.
- 8-bit mode (`four_bit`=0):
  - Each capture forms a byte of {nibble, 4'h0}.
  - Bytes 0x30 are function sets that keep 8-bit mode.
  - Byte 0x20 switches to 4-bit mode with phase 0; no `cmd_valid` is issued for it.
- 4-bit mode:
  - Phase 0 stores the high nibble and `rs`.
  - Phase 1 completes the byte {hi, lo}.
  - If `rs` differs between the two nibbles, the byte is dropped and `err` pulses; phase still returns to 0.
- Command decode (rs=0, highest set bit wins):
  - 1xxxxxxx Set DDRAM address. a[6] selects the line, a[3:0] the column; cursor = {a[6], a[3:0]}. If a[5:4]≠0, the command is ignored and `err` pulses.
  - 001xxxxx Function set: `two_line` = b[3]. DL=1 while in 4-bit mode is ignored.
  - 00001DCB Display control: `disp_on`, `cursor_on`, `blink_on`.
  - 000001I- Entry mode: I=1 increment, I=0 decrement. The shift bit is ignored.
  - 00000001 Clear: sweeps all 32 entries to 0x20, one per cycle, then sets cursor 0 and increment mode.
  - 0000001- Return home: cursor 0.
  - 00000000 No operation, but `cmd_valid` still pulses.
- Data write (rs=1):
  - DDRAM[cursor] ← byte.
  - Cursor then moves ±1 modulo 32 (31→0, 0→31).
- Clear sweep: any byte completed during the 32-cycle sweep is dropped and pulses `err`. Nibble phase still advances.

## Timing
- Latency from the first `clk` edge sampling `lcd_en` low to the `cmd_valid`/`data_valid` pulse is exactly 3 cycles.
- Flags, cursor and DDRAM update on the same edge as the pulse.
- `rd_char` follows `rd_addr` with 1-cycle latency and reflects a write made on the previous edge.
- The clear sweep starts on the cycle after the Clear `cmd_valid` and occupies 32 cycles. Cursor reads 0 on completion.
- Minimum `lcd_en` high and low time is 3 cycles. Shorter pulses are undefined.
- Synchronous `rst` mid-byte or mid-sweep aborts the operation:
  - Returns to 8-bit mode, phase 0.
  - An interrupted sweep leaves DDRAM partially cleared.

## Configuration
- `LCD_RESP_BUSY_EN` defined:
  - `busy` rises with each `cmd_valid`/`data_valid` and stays high for `CLEAR_CYCLES` (Clear) or `CMD_CYCLES` (otherwise).
  - Bytes completed while `busy`=1 are still executed but pulse `err`. This is an overrun check.
  - 8-bit-mode 0x30/0x20 captures do not set `busy`.
- Undefined: `busy` tied to 0 and no overrun checking. The clear sweep behaviour is unchanged.

## Test plan
- Captures 3,3,3,2 (8-bit), then 2,8, 0,8, 0,1, 0,6, 0,F → `four_bit`=1, `two_line`=1, `disp_on`=`cursor_on`=`blink_on`=1, `cursor`=0. DDRAM is all 0x20 after the sweep. 5 `cmd_valid` pulses occur.
- rs=1 nibbles 4,D then 4,1 → DDRAM[0]=0x4D, DDRAM[1]=0x41, `cursor`=2. `data_valid` asserts 3 cycles after each second-nibble en fall.
- Command C,0, then rs=1 4,3 → `cursor` 16, then DDRAM[16]=0x43, `cursor`=17.
- Command C,F, then write 0x58 twice → DDRAM[31]=0x58 and DDRAM[0]=0x58, `cursor`=1. With entry 0x04 from cursor 0 → the next write lands at 0 and the cursor becomes 31.
- Error cases:
  - High nibble with rs=1, low nibble with rs=0 → `err` pulse, no DDRAM change, phase 0.
  - Command 0xA0 → `err` pulse, `cursor` unchanged.
- With `LCD_RESP_BUSY_EN`: a data byte completed 100 cycles after the previous one → `err` pulse. Asserting `rst` between nibbles → the next 0x3 capture is treated as an 8-bit function set.

Source files
------------

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: device-side model of an HD44780-style character LCD
// on the 4-bit write bus. Synchronizes the bus into clk, pairs nibbles,
// decodes commands, holds a 2x16 DDRAM plus cursor/mode flags.
// Optional feature macro: LCD_RESP_BUSY_EN (busy timer and overrun check).
//
// Strobe semantics: cmd_valid / data_valid are single-cycle strobes with no
// back-pressure (no ready); byte_out is meaningful only while one is high,
// and err is an independent single-cycle strobe.
module lcd_hd44780_responder #(
  parameter int CLEAR_CYCLES = 152000,
  parameter int CMD_CYCLES   = 3700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] byte_out,
  output logic [4:0] cursor,
  output logic       four_bit,
  output logic       two_line,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       err
);

  typedef enum logic {ST_IDLE, ST_SWEEP} sweep_state_t;

  sweep_state_t state_q, state_d;
  logic [4:0]   sweep_idx;
  logic         sweep_done;

  // bus sample layout: [6]=en [5]=rs [4]=rw [3:0]=data
  logic [6:0] sync1, sync2;
  logic       en_prev, fall;

  logic       cap_valid, cap_rs, cap_rw;
  logic [3:0] cap_data;

  logic       phase, hi_rs, inc_mode;
  logic [3:0] hi_nib;

  logic       byte_done, pair_err, rw_err, fn8_switch;
  logic [7:0] asm_byte;
  logic       asm_rs;
  logic       exec, drop_err, clear_cmd, addr_err, overrun, pulse_go;

  logic [7:0] ddram [32];

  // two-flop synchronizer shared by all bus lines, plus enable history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      en_prev <= 1'b0;
    end else begin
      sync1   <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      sync2   <= sync1;
      en_prev <= sync2[6];
    end
  end

  assign fall = en_prev & ~sync2[6];

  // latch the synchronized bus on the enable falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_rs    <= 1'b0;
      cap_rw    <= 1'b0;
      cap_data  <= 4'h0;
    end else begin
      cap_valid <= fall;
      cap_rs    <= sync2[5];
      cap_rw    <= sync2[4];
      cap_data  <= sync2[3:0];
    end
  end

  // assemble a byte from the capture and classify it
  always_comb begin
    byte_done  = 1'b0;
    pair_err   = 1'b0;
    rw_err     = 1'b0;
    fn8_switch = 1'b0;
    asm_byte   = 8'h00;
    asm_rs     = 1'b0;
    if (cap_valid) begin
      if (cap_rw) begin
        rw_err = 1'b1;
      end else if (!four_bit) begin
        // 8-bit function sets (0x30 keep, 0x20 switch) never reach decode
        if (!cap_rs && (cap_data == 4'h3 || cap_data == 4'h2)) begin
          fn8_switch = (cap_data == 4'h2);
        end else begin
          byte_done = 1'b1;
          asm_byte  = {cap_data, 4'h0};
          asm_rs    = cap_rs;
        end
      end else if (phase) begin
        if (cap_rs == hi_rs) begin
          byte_done = 1'b1;
          asm_byte  = {hi_nib, cap_data};
          asm_rs    = cap_rs;
        end else begin
          pair_err = 1'b1;
        end
      end
    end
    exec      = byte_done && (state_q == ST_IDLE);
    drop_err  = byte_done && (state_q == ST_SWEEP);
    clear_cmd = exec && !asm_rs && (asm_byte == 8'h01);
    addr_err  = exec && !asm_rs && asm_byte[7] && (asm_byte[5:4] != 2'b00);
    overrun   = exec && busy;
    pulse_go  = exec && !addr_err;
  end

  // clear-sweep state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sweep_idx <= 5'd0;
    end else begin
      state_q   <= state_d;
      sweep_idx <= (state_q == ST_SWEEP) ? sweep_idx + 5'd1 : 5'd0;
    end
  end

  // clear-sweep next state: 32 cycles, one DDRAM entry per cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear_cmd) state_d = ST_SWEEP;
      ST_SWEEP: if (sweep_idx == 5'd31) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign sweep_done = (state_q == ST_SWEEP) && (sweep_idx == 5'd31);

  // nibble pairing, command execution, cursor and flag updates
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      byte_out   <= 8'h00;
      err        <= 1'b0;
      cursor     <= 5'd0;
      four_bit   <= 1'b0;
      two_line   <= 1'b0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      inc_mode   <= 1'b1;
      phase      <= 1'b0;
      hi_rs      <= 1'b0;
      hi_nib     <= 4'h0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      err        <= rw_err | pair_err | drop_err | addr_err | overrun;
      if (cap_valid && !cap_rw && four_bit) begin
        if (!phase) begin
          hi_nib <= cap_data;
          hi_rs  <= cap_rs;
          phase  <= 1'b1;
        end else begin
          phase  <= 1'b0;
        end
      end
      if (fn8_switch) begin
        four_bit <= 1'b1;
        phase    <= 1'b0;
      end
      if (sweep_done) begin
        cursor   <= 5'd0;
        inc_mode <= 1'b1;
      end
      if (exec) begin
        if (asm_rs) begin
          data_valid <= 1'b1;
          byte_out   <= asm_byte;
          cursor     <= inc_mode ? cursor + 5'd1 : cursor - 5'd1;
        end else if (!addr_err) begin
          cmd_valid <= 1'b1;
          byte_out  <= asm_byte;
          if (asm_byte[7]) begin
            cursor <= {asm_byte[6], asm_byte[3:0]};
          end else if (asm_byte[5]) begin
            two_line <= asm_byte[3];
          end else if (asm_byte[4]) begin
            // display/cursor shift is not modelled
          end else if (asm_byte[3]) begin
            disp_on   <= asm_byte[2];
            cursor_on <= asm_byte[1];
            blink_on  <= asm_byte[0];
          end else if (asm_byte[2]) begin
            inc_mode <= asm_byte[1];
          end else if (asm_byte[1]) begin
            cursor <= 5'd0;
          end
          // 0x01 starts the sweep via clear_cmd; 0x00 is a no-op
        end
      end
    end
  end

  // DDRAM write port: sweep fill or data write (never both at once)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_SWEEP) begin
        ddram[sweep_idx] <= 8'h20;
      end else if (exec && asm_rs) begin
        ddram[cursor] <= asm_byte;
      end
    end
  end

  // registered read port for the shadow display
  always_ff @(posedge clk) begin
    if (rst) rd_char <= 8'h20;
    else     rd_char <= ddram[rd_addr];
  end

`ifdef LCD_RESP_BUSY_EN
  localparam int BW = $clog2(CLEAR_CYCLES + 1);
  logic [BW-1:0] busy_cnt;

  // busy timer reloaded by every decoded command or data write
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (pulse_go) begin
      busy_cnt <= clear_cmd ? BW'(CLEAR_CYCLES) : BW'(CMD_CYCLES);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - BW'(1);
    end
  end

  assign busy = (busy_cnt != '0);
`else
  // busy is never modelled here; the timing parameters only matter when it is
  assign busy = (CLEAR_CYCLES < 0) || (CMD_CYCLES < 0);
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed bench for lcd_hd44780_responder.
// Builds with or without LCD_RESP_BUSY_EN; busy-specific vectors are guarded.
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] lcd_data = 4'h0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       cmd_valid, data_valid;
  logic [7:0] byte_out;
  logic [4:0] cursor;
  logic       four_bit, two_line, disp_on, cursor_on, blink_on, busy, err;

  int checks  = 0;
  int errors  = 0;
  int err_cnt = 0;
  int cmd_cnt = 0;
  int e0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  lcd_hd44780_responder #(
    .CLEAR_CYCLES(400),
    .CMD_CYCLES  (150)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .cmd_valid (cmd_valid),
    .data_valid(data_valid),
    .byte_out  (byte_out),
    .cursor    (cursor),
    .four_bit  (four_bit),
    .two_line  (two_line),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .busy      (busy),
    .err       (err)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (err) err_cnt++;
      if (cmd_valid) cmd_cnt++;
      if (cmd_valid || data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, cmd_valid}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pulse_byte", {22'd0, data_valid, cmd_valid, byte_out}, {22'd0, mon_exp});
        end
      end
    end
  end

  // one enable strobe: 4 cycles high, about 4 low; optional latency probe
  task automatic nibble(input logic rs, input logic rw, input logic [3:0] d, input bit lat);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    if (lat) begin
      @(posedge clk);               // first edge sampling en low
      repeat (2) @(posedge clk);
      #1 check("latency_early", {31'd0, data_valid}, 32'd0);
      @(posedge clk);
      #1 check("latency_3cyc", {31'd0, data_valid}, 32'd1);
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
`ifdef LCD_RESP_BUSY_EN
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
`endif
  endtask

  // full 4-bit byte that is expected to be executed
  task automatic send_byte(input logic rs, input logic [7:0] b, input bit lat, input bit nowait);
    if (!nowait) wait_idle();
    exp_q.push_back({rs, ~rs, b});
    nibble(rs, 1'b0, b[7:4], 1'b0);
    nibble(rs, 1'b0, b[3:0], lat);
  endtask

  task automatic read_char(input string tag, input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1 check(tag, {24'd0, rd_char}, {24'd0, exp});
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_rd_char", {24'd0, rd_char}, 32'h20);
    check("rst_cursor", {27'd0, cursor}, 32'd0);
    check("rst_flags", {25'd0, four_bit, two_line, disp_on, cursor_on, blink_on, busy, err},
          32'd0);
    check("rst_pulses", {30'd0, cmd_valid, data_valid}, 32'd0);
    rst = 1'b0;

    // initialization sequence
    nibble(1'b0, 1'b0, 4'h3, 1'b0);
    nibble(1'b0, 1'b0, 4'h3, 1'b0);
    nibble(1'b0, 1'b0, 4'h3, 1'b0);
    check("still_8bit", {31'd0, four_bit}, 32'd0);
    nibble(1'b0, 1'b0, 4'h2, 1'b0);
    check("four_bit_on", {31'd0, four_bit}, 32'd1);
    send_byte(1'b0, 8'h28, 1'b0, 1'b0);
    check("two_line", {31'd0, two_line}, 32'd1);
    send_byte(1'b0, 8'h08, 1'b0, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    send_byte(1'b0, 8'h06, 1'b0, 1'b0);
    send_byte(1'b0, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    check("disp_flags", {29'd0, disp_on, cursor_on, blink_on}, 32'h7);
    check("init_cursor", {27'd0, cursor}, 32'd0);
    check("init_cmd_count", cmd_cnt, 32'd5);
    for (int i = 0; i < 32; i++) read_char("cleared_entry", 5'(i), 8'h20);

    // data writes with latency probe
    send_byte(1'b1, 8'h4D, 1'b1, 1'b0);
    send_byte(1'b1, 8'h41, 1'b1, 1'b0);
    read_char("ddram0_4d", 5'd0, 8'h4D);
    read_char("ddram1_41", 5'd1, 8'h41);
    check("cursor_2", {27'd0, cursor}, 32'd2);

    // line 1 addressing
    send_byte(1'b0, 8'hC0, 1'b0, 1'b0);
    check("cursor_16", {27'd0, cursor}, 32'd16);
    send_byte(1'b1, 8'h43, 1'b0, 1'b0);
    read_char("ddram16_43", 5'd16, 8'h43);
    check("cursor_17", {27'd0, cursor}, 32'd17);

    // wrap 31 -> 0 on increment, 0 -> 31 on decrement
    send_byte(1'b0, 8'hCF, 1'b0, 1'b0);
    check("cursor_31", {27'd0, cursor}, 32'd31);
    send_byte(1'b1, 8'h58, 1'b0, 1'b0);
    send_byte(1'b1, 8'h58, 1'b0, 1'b0);
    read_char("ddram31_58", 5'd31, 8'h58);
    read_char("ddram0_58", 5'd0, 8'h58);
    check("cursor_wrap_1", {27'd0, cursor}, 32'd1);
    send_byte(1'b0, 8'h04, 1'b0, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0, 1'b0);
    check("home_cursor", {27'd0, cursor}, 32'd0);
    send_byte(1'b1, 8'h5A, 1'b0, 1'b0);
    read_char("ddram0_5a", 5'd0, 8'h5A);
    check("cursor_dec_wrap", {27'd0, cursor}, 32'd31);
    send_byte(1'b0, 8'h06, 1'b0, 1'b0);

    // rs mismatch between nibbles: dropped, phase back to 0
    wait_idle();
    e0 = err_cnt;
    nibble(1'b1, 1'b0, 4'h4, 1'b0);
    nibble(1'b0, 1'b0, 4'h1, 1'b0);
    check("rs_mismatch_err", err_cnt - e0, 32'd1);
    read_char("rs_mismatch_nowrite", 5'd31, 8'h58);
    check("rs_mismatch_cursor", {27'd0, cursor}, 32'd31);
    send_byte(1'b1, 8'h33, 1'b0, 1'b0);
    read_char("phase_realigned", 5'd31, 8'h33);
    check("cursor_after_33", {27'd0, cursor}, 32'd0);

    // bad set-address command
    wait_idle();
    e0 = err_cnt;
    nibble(1'b0, 1'b0, 4'hA, 1'b0);
    nibble(1'b0, 1'b0, 4'h0, 1'b0);
    check("addr_a0_err", err_cnt - e0, 32'd1);
    check("addr_a0_cursor", {27'd0, cursor}, 32'd0);

    // read strobe: error, phase unchanged
    e0 = err_cnt;
    nibble(1'b0, 1'b1, 4'h5, 1'b0);
    check("rw_err", err_cnt - e0, 32'd1);
    send_byte(1'b0, 8'h0C, 1'b0, 1'b0);
    check("after_rw_flags", {29'd0, disp_on, cursor_on, blink_on}, 32'h4);

    // byte completed during the clear sweep is dropped
    send_byte(1'b0, 8'h01, 1'b0, 1'b0);
    e0 = err_cnt;
    nibble(1'b1, 1'b0, 4'h3, 1'b0);
    nibble(1'b1, 1'b0, 4'h1, 1'b0);
    check("sweep_drop_err", err_cnt - e0, 32'd1);
    repeat (40) @(negedge clk);
    check("sweep_cursor", {27'd0, cursor}, 32'd0);
    read_char("sweep_ddram0", 5'd0, 8'h20);
    read_char("sweep_ddram31", 5'd31, 8'h20);

`ifdef LCD_RESP_BUSY_EN
    // overrun: second byte completes ~100 cycles after the first
    send_byte(1'b1, 8'h41, 1'b0, 1'b0);
    repeat (84) @(negedge clk);
    e0 = err_cnt;
    check("busy_high", {31'd0, busy}, 32'd1);
    send_byte(1'b1, 8'h42, 1'b0, 1'b1);
    check("overrun_err", err_cnt - e0, 32'd1);
    read_char("overrun_exec", 5'd1, 8'h42);
`endif

    // reset between nibbles returns to 8-bit mode
    wait_idle();
    nibble(1'b0, 1'b0, 4'h2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_four_bit", {31'd0, four_bit}, 32'd0);
    check("rst_mid_two_line", {31'd0, two_line}, 32'd0);
    e0 = cmd_cnt;
    nibble(1'b0, 1'b0, 4'h3, 1'b0);
    check("rst_then_8bit", {31'd0, four_bit}, 32'd0);
    check("fn8_no_pulse", cmd_cnt - e0, 32'd0);
    nibble(1'b0, 1'b0, 4'h2, 1'b0);
    check("rst_then_4bit", {31'd0, four_bit}, 32'd1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
